// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Legacy LC-3b bus types, still used by 16-bit instances.
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Upstream requester bundle plus downstream memory port, grouped as one bus.
// slave = arbiter view, master = requesters/memory (bench) view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DATA_W / 8
);

  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_address;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS*BE_W-1:0]   req_byte_enable;
  logic [NUM_PORTS-1:0]        req_resp;
  logic [DATA_W-1:0]           req_rdata;

  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-1:0]           mem_address;
  logic [DATA_W-1:0]           mem_wdata;
  logic [BE_W-1:0]             mem_byte_enable;
  logic                        mem_resp;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, req_byte_enable,
    output req_resp, req_rdata,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, req_byte_enable,
    input  req_resp, req_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotating-priority encoder: first pending port at or after last_grant+1,
// wrapping around. Purely combinational so other allocators can reuse it.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic                 any_pending_o,
  output logic [IDX_W-1:0]     winner_o
);

  int cand;

  // Walk ports in priority order starting just after the last grant.
  always_comb begin
    any_pending_o = 1'b0;
    winner_o      = '0;
    cand          = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(last_grant_i) + i) % NUM_PORTS;
      if (!any_pending_o && pending_i[cand]) begin
        any_pending_o = 1'b1;
        winner_o      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin N:1 memory-port arbiter, one transaction outstanding.
// The winning request is captured into registers and the downstream port
// is driven only from those registers, so upstream changes during a
// transaction never reach memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mem_port_arbiter_if.slave            bus,
  output logic                         busy,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id
);

  localparam int BE_W = DATA_W / 8;

  typedef logic [$clog2(NUM_PORTS)-1:0] arb_port_t;

  arb_state_t           state_q, state_d;
  arb_port_t            grant_q, grant_d;
  arb_port_t            last_grant_q, last_grant_d;
  logic                 op_write_q, op_write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;

  logic [NUM_PORTS-1:0] pending;
  logic                 any_pending;
  arb_port_t            winner;
  logic [NUM_PORTS-1:0] resp_c;

  assign pending = bus.req_read | bus.req_write;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_pick (
    .pending_i     (pending),
    .last_grant_i  (last_grant_q),
    .any_pending_o (any_pending),
    .winner_o      (winner)
  );

  // State and latched-request registers; last_grant resets to the top port
  // so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= arb_port_t'(NUM_PORTS - 1);
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // Next-state logic: capture the winner in IDLE, complete on mem_resp in BUSY.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_c       = '0;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          state_d      = BUSY;
          grant_d      = winner;
          last_grant_d = winner;
          // write wins when a port illegally raises both strobes
          op_write_d   = bus.req_write[winner];
          addr_d       = bus.req_address[int'(winner)*ADDR_W +: ADDR_W];
          wdata_d      = bus.req_wdata[int'(winner)*DATA_W +: DATA_W];
          be_d         = bus.req_byte_enable[int'(winner)*BE_W +: BE_W];
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          state_d         = IDLE;
          resp_c[grant_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream strobes come from the state register, so an async reset
  // drops them immediately.
  always_comb begin
    busy                = (state_q == BUSY);
    grant_id            = grant_q;
    bus.mem_read        = busy && !op_write_q;
    bus.mem_write       = busy && op_write_q;
    bus.mem_address     = addr_q;
    bus.mem_wdata       = wdata_q;
    bus.mem_byte_enable = be_q;
    bus.req_resp        = resp_c;
    bus.req_rdata       = bus.mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a 2-port 16-bit instance and a
// 3-port 128-bit instance sharing clock and reset.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [1:0]   port;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  be;
    logic [127:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy2, busy3;
  logic       gid2;
  logic [1:0] gid3;

  int n_total = 0;
  int n_bad   = 0;

  exp_t sb2[$];
  exp_t sb3[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16))  bus2 ();
  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(128)) bus3 ();

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus2),
    .busy     (busy2),
    .grant_id (gid2)
  );

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(128)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus3),
    .busy     (busy3),
    .grant_id (gid3)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int port, input bit wr, input logic [15:0] addr,
                              input logic [127:0] wdata, input logic [15:0] be,
                              input logic [127:0] rdata);
    exp_t e;
    e.port  = 2'(port);
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.be    = be;
    e.rdata = rdata;
    return e;
  endfunction

  // ---------------- 2-port instance helpers ----------------
  task automatic beat2(input exp_t e);
    check_val("d2_mem_read",  bus2.mem_read,  !e.wr);
    check_val("d2_mem_write", bus2.mem_write, e.wr);
    check_val("d2_mem_addr",  bus2.mem_address, e.addr);
    check_val("d2_resp_wait", bus2.req_resp, 0);
    if (e.wr) begin
      check_val("d2_mem_wdata", bus2.mem_wdata, e.wdata[15:0]);
      check_val("d2_mem_be",    bus2.mem_byte_enable, e.be[1:0]);
    end
  endtask

  task automatic start2(output exp_t e, output int wait_n);
    wait_n = 0;
    while (!(bus2.mem_read || bus2.mem_write) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_val("d2_strobe_seen", bus2.mem_read | bus2.mem_write, 1);
    e = sb2.pop_front();
    check_val("d2_grant_id", gid2, e.port);
    check_val("d2_busy", busy2, 1);
    beat2(e);
  endtask

  task automatic finish2(input exp_t e, input int lat, input bit drop);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      beat2(e);
    end
    bus2.mem_rdata = e.rdata[15:0];
    bus2.mem_resp  = 1'b1;
    #1;
    check_val("d2_req_resp",  bus2.req_resp, 128'd1 << e.port);
    check_val("d2_req_rdata", bus2.req_rdata, e.rdata[15:0]);
    @(negedge clk);
    bus2.mem_resp = 1'b0;
    if (drop) begin
      bus2.req_read[e.port[0]]  = 1'b0;
      bus2.req_write[e.port[0]] = 1'b0;
    end
    #1;
    check_val("d2_strobe_off", {bus2.mem_read, bus2.mem_write}, 0);
    check_val("d2_busy_off",   busy2, 0);
    check_val("d2_resp_off",   bus2.req_resp, 0);
  endtask

  // ---------------- 3-port instance helpers ----------------
  task automatic beat3(input exp_t e);
    check_val("d3_mem_read",  bus3.mem_read,  !e.wr);
    check_val("d3_mem_write", bus3.mem_write, e.wr);
    check_val("d3_mem_addr",  bus3.mem_address, e.addr);
    check_val("d3_resp_wait", bus3.req_resp, 0);
    if (e.wr) begin
      check_val("d3_mem_wdata", bus3.mem_wdata, e.wdata);
      check_val("d3_mem_be",    bus3.mem_byte_enable, e.be);
    end
  endtask

  task automatic serve3(input int lat);
    exp_t e;
    int   n = 0;
    while (!(bus3.mem_read || bus3.mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("d3_strobe_seen", bus3.mem_read | bus3.mem_write, 1);
    e = sb3.pop_front();
    check_val("d3_grant_id", gid3, e.port);
    beat3(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      beat3(e);
    end
    bus3.mem_rdata = e.rdata;
    bus3.mem_resp  = 1'b1;
    #1;
    check_val("d3_req_resp",  bus3.req_resp, 128'd1 << e.port);
    check_val("d3_req_rdata", bus3.req_rdata, e.rdata);
    @(negedge clk);
    bus3.mem_resp = 1'b0;
    bus3.req_read[e.port]  = 1'b0;
    bus3.req_write[e.port] = 1'b0;
    #1;
    check_val("d3_busy_off", busy3, 0);
    check_val("d3_resp_off", bus3.req_resp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;

    bus2.req_read = '0; bus2.req_write = '0; bus2.req_address = '0;
    bus2.req_wdata = '0; bus2.req_byte_enable = '0;
    bus2.mem_resp = 1'b0; bus2.mem_rdata = '0;
    bus3.req_read = '0; bus3.req_write = '0; bus3.req_address = '0;
    bus3.req_wdata = '0; bus3.req_byte_enable = '0;
    bus3.mem_resp = 1'b0; bus3.mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_mem_read",  bus2.mem_read, 0);
    check_val("rst_mem_write", bus2.mem_write, 0);
    check_val("rst_busy",      busy2, 0);
    check_val("rst_grant_id",  gid2, 0);
    check_val("rst_mem_addr",  bus2.mem_address, 0);
    check_val("rst_req_resp",  bus2.req_resp, 0);
    check_val("rst_d3_busy",   busy3, 0);
    check_val("rst_d3_be",     bus3.mem_byte_enable, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read from port 0, 3-cycle memory
    bus2.req_read[0] = 1'b1;
    bus2.req_address[15:0] = 16'h1234;
    sb2.push_back(mk(0, 0, 16'h1234, 0, 0, 128'hBEEF));
    start2(e, n);
    check_val("read_latency", n, 1);
    finish2(e, 3, 1'b1);

    // Masked write from port 1
    @(negedge clk);
    bus2.req_write[1] = 1'b1;
    bus2.req_address[31:16] = 16'h0040;
    bus2.req_wdata[31:16] = 16'hA5A5;
    bus2.req_byte_enable[3:2] = 2'b10;
    sb2.push_back(mk(1, 1, 16'h0040, 128'hA5A5, 16'h2, 128'h0));
    start2(e, n);
    finish2(e, 2, 1'b1);

    // Upstream address change while busy, then a spurious idle mem_resp
    @(negedge clk);
    bus2.req_read[0] = 1'b1;
    bus2.req_address[15:0] = 16'h0100;
    sb2.push_back(mk(0, 0, 16'h0100, 0, 0, 128'h5A5A));
    start2(e, n);
    bus2.req_address[15:0] = 16'hFFFF;
    finish2(e, 2, 1'b1);
    @(negedge clk);
    bus2.mem_resp = 1'b1;
    #1;
    check_val("spurious_resp", bus2.req_resp, 0);
    @(negedge clk);
    bus2.mem_resp = 1'b0;
    #1;
    check_val("spurious_busy",   busy2, 0);
    check_val("spurious_strobe", {bus2.mem_read, bus2.mem_write}, 0);

    // Contention from reset with a 1-cycle memory
    rst_n = 1'b0;
    @(negedge clk);
    bus2.req_read = 2'b11;
    bus2.req_address = {16'h2000, 16'h1000};
    sb2.push_back(mk(0, 0, 16'h1000, 0, 0, 128'h1111));
    sb2.push_back(mk(1, 0, 16'h2000, 0, 0, 128'h2222));
    sb2.push_back(mk(0, 0, 16'h1000, 0, 0, 128'h3333));
    sb2.push_back(mk(1, 0, 16'h2000, 0, 0, 128'h4444));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start2(e, n);
      check_val("contend_gap", n, 1);
      finish2(e, 0, 1'b0);
    end
    bus2.req_read = 2'b00;

    // Reset two cycles into a port-1 read
    @(negedge clk);
    bus2.req_read[1] = 1'b1;
    bus2.req_address[31:16] = 16'h0777;
    sb2.push_back(mk(1, 0, 16'h0777, 0, 0, 128'h0));
    start2(e, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_mem_read", bus2.mem_read, 0);
    check_val("midrst_busy",     busy2, 0);
    check_val("midrst_resp",     bus2.req_resp, 0);
    check_val("midrst_grant",    gid2, 0);
    bus2.req_read[0] = 1'b1;
    bus2.req_address[15:0] = 16'h0500;
    @(negedge clk);
    @(negedge clk);
    check_val("midrst_held", {bus2.mem_read, bus2.mem_write}, 0);
    rst_n = 1'b1;
    sb2.push_back(mk(0, 0, 16'h0500, 0, 0, 128'h0A0A));
    sb2.push_back(mk(1, 0, 16'h0777, 0, 0, 128'h0B0B));
    start2(e, n);
    finish2(e, 1, 1'b1);
    start2(e, n);
    finish2(e, 1, 1'b1);

    // 3-port, 128-bit: make last_grant=1, then ports 1 and 2 contend
    @(negedge clk);
    bus3.req_read[1] = 1'b1;
    bus3.req_address[31:16] = 16'h0011;
    sb3.push_back(mk(1, 0, 16'h0011, 0, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    serve3(1);
    @(negedge clk);
    bus3.req_write[1] = 1'b1;
    bus3.req_address[31:16] = 16'h0022;
    bus3.req_wdata[255:128] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    bus3.req_byte_enable[31:16] = 16'hFFFF;
    bus3.req_read[2] = 1'b1;
    bus3.req_address[47:32] = 16'h0033;
    sb3.push_back(mk(2, 0, 16'h0033, 0, 0, 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_5678));
    sb3.push_back(mk(1, 1, 16'h0022, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
                     16'hFFFF, 128'h7777));
    serve3(2);
    serve3(0);

    check_val("sb2_drained", sb2.size(), 0);
    check_val("sb3_drained", sb3.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
